// File: rtl/fix_pkg.sv
// Shared state type and byte constants for the FIX stream front end.
package fix_pkg;

    typedef enum logic [2:0] {IDLE, TAG, VAL, CKV, SKIP, DONE} state_t;

    localparam logic [7:0]  ASCII_0   = 8'h30;
    localparam logic [7:0]  ASCII_9   = 8'h39;
    localparam logic [7:0]  ASCII_8   = 8'h38;
    localparam logic [7:0]  SOH       = 8'h01;
    localparam logic [7:0]  EQ        = 8'h3D;
    localparam logic [15:0] TAG_CKSUM = 16'h3130;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/fix_cksum_acc.sv
// Running modulo-256 message sum, per-field snapshot, and decimal checksum accumulator.
module fix_cksum_acc
    import fix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       start_i,
    input  logic       add_i,
    input  logic       snap_i,
    input  logic       ck_clr_i,
    input  logic       ck_digit_i,
    output logic [7:0] fsum_o,
    output logic [9:0] ck_acc_o,
    output logic [1:0] ck_digits_o
);

    logic [7:0] sum_q, sum_d;
    logic [7:0] fsum_q, fsum_d;
    logic [9:0] ck_acc_q, ck_acc_d;
    logic [1:0] ck_digits_q, ck_digits_d;
    logic [7:0] digit;

    always_comb begin
        sum_d       = sum_q;
        fsum_d      = fsum_q;
        ck_acc_d    = ck_acc_q;
        ck_digits_d = ck_digits_q;
        digit       = data_i - ASCII_0;

        if (start_i) begin
            sum_d  = data_i;
            fsum_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + data_i;
        end
        // Snapshot includes the byte that closes the previous field.
        if (snap_i) begin
            fsum_d = sum_q + data_i;
        end

        if (ck_clr_i) begin
            ck_acc_d    = '0;
            ck_digits_d = '0;
        end else if (ck_digit_i) begin
            ck_acc_d    = ck_acc_q * 10'd10 + {2'b00, digit};
            ck_digits_d = ck_digits_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            fsum_q      <= '0;
            ck_acc_q    <= '0;
            ck_digits_q <= '0;
        end else begin
            sum_q       <= sum_d;
            fsum_q      <= fsum_d;
            ck_acc_q    <= ck_acc_d;
            ck_digits_q <= ck_digits_d;
        end
    end

    assign fsum_o      = fsum_q;
    assign ck_acc_o    = ck_acc_q;
    assign ck_digits_o = ck_digits_q;

endmodule

// File: rtl/fix_stream_ctrl.sv
// Frames FIX messages from "8=" to "10=nnn<SOH>", strips delimiters for the
// tag/value extractor, and reports checksum/format status per message.
module fix_stream_ctrl
    import fix_pkg::*;
#(
    parameter int unsigned MAX_TAG_LEN   = 4,
    parameter int unsigned MAX_VALUE_LEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    output logic [7:0] data_o,
    output logic       start_tag_o,
    output logic       start_value_o,
    output logic       msg_done_o,
    output logic       cksum_err_o,
    output logic       fmt_err_o,
    output logic [7:0] field_cnt_o,
    output logic [7:0] cksum_o
);

    localparam int unsigned TL_W = $clog2(MAX_TAG_LEN + 1);
    localparam int unsigned VL_W = $clog2(MAX_VALUE_LEN + 1);

    state_t          state_q, state_d;
    logic [TL_W-1:0] tag_len_q, tag_len_d;
    logic [15:0]     tag_sr_q, tag_sr_d;
    logic [VL_W-1:0] val_len_q, val_len_d;
    logic [7:0]      field_cnt_q, field_cnt_d;
    logic [7:0]      data_q, data_d;
    logic            start_tag_q, start_tag_d;
    logic            start_value_q, start_value_d;
    logic            msg_done_q, msg_done_d;
    logic            cksum_err_q, cksum_err_d;
    logic            fmt_err_q, fmt_err_d;
    logic [7:0]      field_out_q, field_out_d;
    logic [7:0]      cksum_out_q, cksum_out_d;

    logic       hs;
    logic       acc_start, acc_add, acc_snap, ck_clr, ck_digit;
    logic       done_now, done_fmt;
    logic [7:0] fsum;
    logic [9:0] ck_acc;
    logic [1:0] ck_digits;

    // Combinational on rst so no byte can be taken while reset is held.
    assign in_ready_o = !rst && (state_q != DONE);
    assign hs         = in_valid_i && in_ready_o;

    fix_cksum_acc u_cksum (
        .clk         (clk),
        .rst         (rst),
        .data_i      (in_data_i),
        .start_i     (acc_start),
        .add_i       (acc_add),
        .snap_i      (acc_snap),
        .ck_clr_i    (ck_clr),
        .ck_digit_i  (ck_digit),
        .fsum_o      (fsum),
        .ck_acc_o    (ck_acc),
        .ck_digits_o (ck_digits)
    );

    always_comb begin
        state_d       = state_q;
        tag_len_d     = tag_len_q;
        tag_sr_d      = tag_sr_q;
        val_len_d     = val_len_q;
        field_cnt_d   = field_cnt_q;
        data_d        = data_q;
        start_tag_d   = 1'b0;
        start_value_d = 1'b0;
        msg_done_d    = 1'b0;
        cksum_err_d   = cksum_err_q;
        fmt_err_d     = fmt_err_q;
        field_out_d   = field_out_q;
        cksum_out_d   = cksum_out_q;
        acc_start     = 1'b0;
        acc_add       = 1'b0;
        acc_snap      = 1'b0;
        ck_clr        = 1'b0;
        ck_digit      = 1'b0;
        done_now      = 1'b0;
        done_fmt      = 1'b0;

        if (state_q == DONE) begin
            state_d = IDLE;
        end else if (hs) begin
            acc_add = (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (in_data_i == ASCII_8) begin
                        state_d     = TAG;
                        tag_len_d   = TL_W'(1);
                        tag_sr_d    = {8'h00, in_data_i};
                        field_cnt_d = '0;
                        acc_start   = 1'b1;
                        start_tag_d = 1'b1;
                        data_d      = in_data_i;
                    end
                end
                TAG: begin
                    if (in_data_i == EQ) begin
                        if (tag_len_q == '0) begin
                            state_d = SKIP;
                        end else if (tag_len_q == TL_W'(2) && tag_sr_q == TAG_CKSUM) begin
                            state_d = CKV;
                            ck_clr  = 1'b1;
                        end else begin
                            state_d   = VAL;
                            val_len_d = '0;
                            if (field_cnt_q != 8'hFF) field_cnt_d = field_cnt_q + 8'd1;
                        end
                    end else if (in_data_i == SOH || tag_len_q == TL_W'(MAX_TAG_LEN)) begin
                        state_d = SKIP;
                    end else begin
                        tag_len_d   = tag_len_q + TL_W'(1);
                        tag_sr_d    = {tag_sr_q[7:0], in_data_i};
                        start_tag_d = 1'b1;
                        data_d      = in_data_i;
                    end
                end
                VAL: begin
                    if (in_data_i == SOH) begin
                        state_d   = TAG;
                        acc_snap  = 1'b1;
                        tag_len_d = '0;
                        tag_sr_d  = '0;
                    end else if (in_data_i != EQ) begin
                        if (val_len_q == VL_W'(MAX_VALUE_LEN)) begin
                            state_d = SKIP;
                        end else begin
                            val_len_d     = val_len_q + VL_W'(1);
                            start_value_d = 1'b1;
                            data_d        = in_data_i;
                        end
                    end
                end
                CKV: begin
                    if (is_digit(in_data_i)) begin
                        if (ck_digits == 2'd3) begin
                            state_d = SKIP;
                        end else begin
                            ck_digit      = 1'b1;
                            start_value_d = 1'b1;
                            data_d        = in_data_i;
                        end
                    end else if (in_data_i == SOH) begin
                        done_now = 1'b1;
                        done_fmt = (ck_digits != 2'd3);
                    end else begin
                        state_d = SKIP;
                    end
                end
                SKIP: begin
                    if (in_data_i == SOH) begin
                        done_now = 1'b1;
                        done_fmt = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (done_now) begin
            state_d     = DONE;
            msg_done_d  = 1'b1;
            fmt_err_d   = done_fmt;
            cksum_err_d = !done_fmt && (ck_acc != {2'b00, fsum});
            field_out_d = field_cnt_q;
            cksum_out_d = fsum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tag_len_q     <= '0;
            tag_sr_q      <= '0;
            val_len_q     <= '0;
            field_cnt_q   <= '0;
            data_q        <= '0;
            start_tag_q   <= 1'b0;
            start_value_q <= 1'b0;
            msg_done_q    <= 1'b0;
            cksum_err_q   <= 1'b0;
            fmt_err_q     <= 1'b0;
            field_out_q   <= '0;
            cksum_out_q   <= '0;
        end else begin
            state_q       <= state_d;
            tag_len_q     <= tag_len_d;
            tag_sr_q      <= tag_sr_d;
            val_len_q     <= val_len_d;
            field_cnt_q   <= field_cnt_d;
            data_q        <= data_d;
            start_tag_q   <= start_tag_d;
            start_value_q <= start_value_d;
            msg_done_q    <= msg_done_d;
            cksum_err_q   <= cksum_err_d;
            fmt_err_q     <= fmt_err_d;
            field_out_q   <= field_out_d;
            cksum_out_q   <= cksum_out_d;
        end
    end

    assign data_o        = data_q;
    assign start_tag_o   = start_tag_q;
    assign start_value_o = start_value_q;
    assign msg_done_o    = msg_done_q;
    assign cksum_err_o   = cksum_err_q;
    assign fmt_err_o     = fmt_err_q;
    assign field_cnt_o   = field_out_q;
    assign cksum_o       = cksum_out_q;

endmodule

// File: tb/tb_fix_stream_ctrl.sv
// Bench for fix_stream_ctrl: message-level reference model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_fix_stream_ctrl;

    localparam logic [7:0] B_SOH = 8'h01;
    localparam logic [7:0] B_EQ  = 8'h3D;
    localparam int MAXT = 4;
    localparam int MAXV = 32;
    localparam int P_IDLE = 0, P_TAG = 1, P_VAL = 2, P_CK = 3, P_SKIP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready_o;
    logic [7:0] data_o;
    logic       start_tag_o, start_value_o, msg_done_o, cksum_err_o, fmt_err_o;
    logic [7:0] field_cnt_o, cksum_o;

    fix_stream_ctrl #(.MAX_TAG_LEN(4), .MAX_VALUE_LEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid),
        .in_data_i     (in_data),
        .in_ready_o    (in_ready_o),
        .data_o        (data_o),
        .start_tag_o   (start_tag_o),
        .start_value_o (start_value_o),
        .msg_done_o    (msg_done_o),
        .cksum_err_o   (cksum_err_o),
        .fmt_err_o     (fmt_err_o),
        .field_cnt_o   (field_cnt_o),
        .cksum_o       (cksum_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (message-level) ----------------
    int         ph = P_IDLE;
    logic [7:0] m_msg[$];
    logic [7:0] m_tag[$];
    logic [7:0] m_ck[$];
    int         m_vlen = 0;
    int         m_nf = 0;
    logic [7:0] m_fsum = '0;
    bit         m_done = 1'b0;
    logic [7:0] e_data = '0;
    bit         e_tag = 1'b0, e_val = 1'b0, e_done = 1'b0, e_ckerr = 1'b0, e_fmt = 1'b0;
    logic [7:0] e_field = '0, e_cksum = '0;

    task automatic m_reset();
        ph = P_IDLE; m_msg.delete(); m_tag.delete(); m_ck.delete();
        m_vlen = 0; m_nf = 0; m_fsum = '0; m_done = 1'b0;
        e_data = '0; e_tag = 1'b0; e_val = 1'b0; e_done = 1'b0;
        e_ckerr = 1'b0; e_fmt = 1'b0; e_field = '0; e_cksum = '0;
    endtask

    task automatic m_emit(input bit is_tag, input logic [7:0] b);
        e_data = b;
        e_tag  = is_tag;
        e_val  = !is_tag;
    endtask

    task automatic m_finish(input bit fmt);
        int v = 0;
        foreach (m_ck[i]) v = v * 10 + int'(m_ck[i] - 8'h30);
        e_done  = 1'b1;
        e_fmt   = fmt;
        e_ckerr = !fmt && (v != int'(m_fsum));
        e_field = 8'(m_nf);
        e_cksum = m_fsum;
        m_done  = 1'b1;
        ph      = P_IDLE;
    endtask

    task automatic m_byte(input logic [7:0] b);
        bit dig;
        int s;
        dig = (b >= 8'h30) && (b <= 8'h39);
        if (ph == P_IDLE) begin
            if (b == 8'h38) begin
                m_msg = {b}; m_tag = {b}; m_nf = 0; m_fsum = '0;
                ph = P_TAG;
                m_emit(1'b1, b);
            end
            return;
        end
        m_msg.push_back(b);
        case (ph)
            P_TAG: begin
                if (b == B_EQ) begin
                    if (m_tag.size() == 0) ph = P_SKIP;
                    else if (m_tag.size() == 2 && m_tag[0] == 8'h31 && m_tag[1] == 8'h30) begin
                        m_ck.delete();
                        ph = P_CK;
                    end else begin
                        if (m_nf < 255) m_nf++;
                        m_vlen = 0;
                        ph = P_VAL;
                    end
                end else if (b == B_SOH || m_tag.size() == MAXT) ph = P_SKIP;
                else begin
                    m_tag.push_back(b);
                    m_emit(1'b1, b);
                end
            end
            P_VAL: begin
                if (b == B_SOH) begin
                    s = 0;
                    foreach (m_msg[i]) s += int'(m_msg[i]);
                    m_fsum = 8'(s % 256);
                    m_tag.delete();
                    ph = P_TAG;
                end else if (b != B_EQ) begin
                    if (m_vlen == MAXV) ph = P_SKIP;
                    else begin
                        m_vlen++;
                        m_emit(1'b0, b);
                    end
                end
            end
            P_CK: begin
                if (dig) begin
                    if (m_ck.size() == 3) ph = P_SKIP;
                    else begin
                        m_ck.push_back(b);
                        m_emit(1'b0, b);
                    end
                end else if (b == B_SOH) m_finish(m_ck.size() != 3);
                else ph = P_SKIP;
            end
            P_SKIP: if (b == B_SOH) m_finish(1'b1);
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) m_reset();
        else begin
            e_tag = 1'b0; e_val = 1'b0; e_done = 1'b0;
            if (m_done) m_done = 1'b0;
            else if (in_valid) m_byte(in_data);
        end
    end

    // ---------------- per-cycle compare and monitor ----------------
    logic [8:0] log_q[$];
    int         done_cnt = 0;
    int         rdy_low = 0;
    logic       r_ckerr = 1'b0, r_fmt = 1'b0;
    logic [7:0] r_field = '0, r_cksum = '0;

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("in_ready",    32'(in_ready_o),    32'(!rst && !m_done));
            chk("data",        32'(data_o),        32'(e_data));
            chk("start_tag",   32'(start_tag_o),   32'(e_tag));
            chk("start_value", 32'(start_value_o), 32'(e_val));
            chk("msg_done",    32'(msg_done_o),    32'(e_done));
            chk("cksum_err",   32'(cksum_err_o),   32'(e_ckerr));
            chk("fmt_err",     32'(fmt_err_o),     32'(e_fmt));
            chk("field_cnt",   32'(field_cnt_o),   32'(e_field));
            chk("cksum",       32'(cksum_o),       32'(e_cksum));
            if (!rst && !in_ready_o) rdy_low++;
            if (start_tag_o || start_value_o) log_q.push_back({start_tag_o, data_o});
            if (msg_done_o) begin
                done_cnt++;
                r_ckerr = cksum_err_o; r_fmt = fmt_err_o;
                r_field = field_cnt_o; r_cksum = cksum_o;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] tx[$];

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            c = s[i];
            tx.push_back(c == 8'h7C ? B_SOH : c);
        end
    endtask

    task automatic load_str(input string s);
        tx.delete();
        push_str(s);
    endtask

    task automatic push_dec(input int v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            int p = 1;
            for (int k = 0; k < i; k++) p *= 10;
            tx.push_back(8'(8'h30 + (v / p) % 10));
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n >= 8) begin
                checks++; errors++;
                $display("FAIL handshake: got no in_ready for %0d cycles expected acceptance", n);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_tx(input int mode);
        foreach (tx[i]) begin
            send(tx[i]);
            if (mode == 1) idle(1);
            else if (mode == 2 && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_cnt == prev && n < 6) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == prev) begin
            errors++;
            $display("FAIL msg_done_timeout: got 0 pulses expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int mode);
        int prev;
        log_q.delete();
        prev = done_cnt;
        send_tx(mode);
        wait_done(prev);
    endtask

    task automatic check_status(input string nm, input logic ce, input logic fe,
                                input logic [7:0] fc, input logic [7:0] cs);
        chk({nm, "_cksum_err"}, 32'(r_ckerr), 32'(ce));
        chk({nm, "_fmt_err"},   32'(r_fmt),   32'(fe));
        chk({nm, "_field_cnt"}, 32'(r_field), 32'(fc));
        chk({nm, "_cksum"},     32'(r_cksum), 32'(cs));
    endtask

    task automatic check_good(input string nm);
        logic [8:0] exp_log[7];
        exp_log = '{9'h138, 9'h041, 9'h131, 9'h130, 9'h031, 9'h038, 9'h033};
        check_status(nm, 1'b0, 1'b0, 8'd1, 8'hB7);
        chk({nm, "_log_len"}, 32'(log_q.size()), 32'd7);
        if (log_q.size() == 7)
            for (int i = 0; i < 7; i++) chk({nm, "_log"}, 32'(log_q[i]), 32'(exp_log[i]));
    endtask

    task automatic build_rand();
        int start, nf, s, mode, ck, ng;
        tx.delete();
        if ($urandom_range(0, 15) == 0) begin
            logic [7:0] alpha[7];
            alpha = '{8'h38, 8'h3D, 8'h01, 8'h31, 8'h30, 8'h41, 8'h39};
            for (int i = 0; i < 15; i++) tx.push_back(alpha[$urandom_range(0, 6)]);
            return;
        end
        if ($urandom_range(0, 5) == 0) begin
            ng = int'($urandom_range(1, 3));
            for (int i = 0; i < ng; i++) tx.push_back(8'($urandom_range(8'h39, 8'h7E)));
        end
        start = tx.size();
        push_str("8=");
        for (int i = 0; i < int'($urandom_range(0, 6)); i++) tx.push_back(8'($urandom_range(8'h41, 8'h5A)));
        tx.push_back(B_SOH);
        nf = int'($urandom_range(0, 3));
        for (int f = 0; f < nf; f++) begin
            int tl, vl;
            tl = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(1, 4));
            for (int i = 0; i < tl; i++) tx.push_back(8'($urandom_range(8'h31, 8'h39)));
            tx.push_back(B_EQ);
            vl = ($urandom_range(0, 9) == 0) ? 33 : int'($urandom_range(0, 8));
            for (int i = 0; i < vl; i++) tx.push_back(8'($urandom_range(8'h41, 8'h5A)));
            tx.push_back(B_SOH);
        end
        s = 0;
        for (int i = start; i < tx.size(); i++) s += int'(tx[i]);
        s = s % 256;
        mode = int'($urandom_range(0, 9));
        push_str("10=");
        if (mode == 0) begin
            ck = s + 1 + int'($urandom_range(0, 50));
            push_dec(ck, 3);
        end else if (mode == 1) push_dec(s % 100, 2);
        else if (mode == 2) push_dec(s, 4);
        else push_dec(s, 3);
        tx.push_back(B_SOH);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int prev;
        rst = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready_o),  32'd0);
        chk("rst_data",      32'(data_o),      32'd0);
        chk("rst_msg_done",  32'(msg_done_o),  32'd0);
        chk("rst_field_cnt", 32'(field_cnt_o), 32'd0);
        chk("rst_cksum",     32'(cksum_o),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        load_str("8=A|10=183|");   run(0); check_good("good");
        load_str("8=A|10=184|");   run(0); check_status("badck", 1'b1, 1'b0, 8'd1, 8'hB7);
        load_str("A|8=A|10=183|"); run(0); check_good("garbage");

        load_str("8=A|12345=X|");  run(0); check_status("longtag", 1'b0, 1'b1, 8'd1, 8'hB7);
        chk("longtag_log_len", 32'(log_q.size()), 32'd6);
        load_str("8=A|10=183|");   run(0); check_good("after_longtag");

        rdy_low = 0;
        load_str("8=A|10=183|");   run(1); idle(2); check_good("toggle");
        chk("toggle_ready_low", 32'(rdy_low), 32'd1);

        load_str("8=AB");
        send_tx(0);
        prev = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_data",      32'(data_o),        32'd0);
        chk("rstmid_strobes",   32'({start_tag_o, start_value_o}), 32'd0);
        chk("rstmid_status",    32'({msg_done_o, cksum_err_o, fmt_err_o}), 32'd0);
        chk("rstmid_field_cnt", 32'(field_cnt_o),   32'd0);
        chk("rstmid_cksum",     32'(cksum_o),       32'd0);
        idle(3);
        chk("rstmid_no_done",   32'(done_cnt),      32'(prev));
        load_str("8=A|10=183|");   run(0); check_good("after_rst");

        load_str("8=A|1234=Z|10=025|"); run(2); check_status("tag4", 1'b0, 1'b0, 8'd2, 8'h19);

        tx.delete(); push_str("8="); repeat (32) tx.push_back(8'h41); push_str("|10=150|");
        run(0); check_status("val32", 1'b0, 1'b0, 8'd1, 8'h96);
        tx.delete(); push_str("8="); repeat (33) tx.push_back(8'h41); push_str("|10=150|");
        run(0); check_status("val33", 1'b0, 1'b1, 8'd1, 8'h00);

        tx.delete(); push_str("8=A|"); repeat (259) push_str("9=B|"); push_str("10=226|");
        run(2); check_status("sat", 1'b0, 1'b0, 8'd255, 8'hE2);

        for (int m = 0; m < 80; m++) begin
            build_rand();
            send_tx(2);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
